// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its baud generator.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } uart_state_e;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 173;
  localparam int UART_FRAME_BITS           = 10;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side signals around uart_tx_arbiter.
// req_lock is carried always; only builds with UART_TX_ARBITER_LOCK_EN connect it.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]         req_valid;
  logic [8*N_REQ-1:0]       req_data;
  logic [N_REQ-1:0]         req_lock;
  logic [N_REQ-1:0]         req_ready;
  logic                     tx_do_sample;
  logic [7:0]               tx_data;
  logic                     tx_start;
  logic                     tx_busy;
  logic [$clog2(N_REQ)-1:0] grant;
  logic                     active;

  modport master (
    input  req_valid, req_data, req_lock, tx_busy,
    output req_ready, tx_do_sample, tx_data, tx_start, grant, active
  );

  modport slave (
    output req_valid, req_data, req_lock, tx_busy,
    input  req_ready, tx_do_sample, tx_data, tx_start, grant, active
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Free-running baud tick: counts down from CLKS_PER_BIT-1, pulses for one cycle at zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 173
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= RELOAD;
    end else if (r_cnt == '0) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from N_REQ requesters into a single UART transmitter.
// Optional packet hold via req_lock when UART_TX_ARBITER_LOCK_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
`ifdef UART_TX_ARBITER_LOCK_EN
  input  logic [N_REQ-1:0]         req_lock,
`endif
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_do_sample,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant,
  output logic                     active
);
  localparam int GW = $clog2(N_REQ);
  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] START     = ST_START;
  localparam logic [1:0] WAIT_BUSY = ST_WAIT_BUSY;
  localparam logic [1:0] WAIT_DONE = ST_WAIT_DONE;

  logic [1:0]       r_state;
  logic [GW-1:0]    r_grant;
  logic [7:0]       r_tx_data;
  logic             r_tx_start;

  logic [N_REQ-1:0] w_eligible;
  logic [GW-1:0]    w_winner;
  logic [GW-1:0]    w_cand;
  logic             w_found;
  logic             w_accept;
  logic [7:0]       w_bytes [N_REQ];

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .o_tick (tx_do_sample)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign w_bytes[gi] = req_data[8*gi +: 8];
    end
  endgenerate

`ifdef UART_TX_ARBITER_LOCK_EN
  // A held lock on the last winner masks every other requester.
  always_comb begin
    w_eligible = req_valid;
    if (req_lock[r_grant]) begin
      w_eligible = req_valid & (N_REQ'(1) << r_grant);
    end
  end
`else
  assign w_eligible = req_valid;
`endif

  // Scan grant+1 .. grant (wrapping) so the previous winner is considered last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_grant;
    w_cand   = r_grant;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = (w_cand == GW'(N_REQ - 1)) ? '0 : w_cand + 1'b1;
      if (!w_found && w_eligible[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  assign w_accept  = !rst && (r_state == IDLE) && !tx_busy && w_found;
  assign req_ready = w_accept ? (N_REQ'(1) << w_winner) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= GW'(N_REQ - 1);
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_tx_data  <= w_bytes[w_winner];
            r_grant    <= w_winner;
            r_tx_start <= 1'b1;
            r_state    <= START;
          end
        end
        START:     r_state <= WAIT_BUSY;
        WAIT_BUSY: if (tx_busy) r_state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign grant    = r_grant;
  assign active   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART shifter driving tx_busy.
// Lock scenario is built only when UART_TX_ARBITER_LOCK_EN is defined.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N   = 4;
  localparam int CPB = 173;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (bus.req_valid),
    .req_data     (bus.req_data),
`ifdef UART_TX_ARBITER_LOCK_EN
    .req_lock     (bus.req_lock),
`endif
    .req_ready    (bus.req_ready),
    .tx_do_sample (bus.tx_do_sample),
    .tx_data      (bus.tx_data),
    .tx_start     (bus.tx_start),
    .tx_busy      (bus.tx_busy),
    .grant        (bus.grant),
    .active       (bus.active)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   last_ready_cyc = -100;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitter model: it is not reset by rst, so a frame keeps shifting across a reset.
  logic [9:0] tx_sh   = 10'h3FF;
  int         tx_bits = 0;
  logic       tx_busy_m = 1'b0;
  assign bus.tx_busy = tx_busy_m;

  always @(posedge clk) begin
    if (bus.tx_start && !tx_busy_m) begin
      tx_sh     <= {1'b1, bus.tx_data, 1'b0};
      tx_bits   <= 0;
      tx_busy_m <= 1'b1;
    end else if (tx_busy_m && bus.tx_do_sample) begin
      if (tx_bits == UART_FRAME_BITS - 1) tx_busy_m <= 1'b0;
      tx_sh   <= {1'b1, tx_sh[9:1]};
      tx_bits <= tx_bits + 1;
    end
  end

  // Monitor: compares every accept and every start against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_ready != '0) begin
        if (exp_q.size() == 0) check("unexpected_ready", 32'(bus.req_ready), 32'd0);
        else check("ready_onehot", 32'(bus.req_ready), 32'd1 << exp_q[0].idx);
        check("ready_only_idle", {30'd0, bus.active, bus.tx_busy}, 32'd0);
        last_ready_cyc = cyc;
      end
      if (bus.tx_start) begin
        check("start_latency", 32'(cyc - last_ready_cyc), 32'd1);
        check("start_no_busy", 32'(bus.tx_busy), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'(bus.tx_start), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("tx_data", 32'(bus.tx_data), 32'(e.data));
          check("grant", 32'(bus.grant), 32'(e.idx));
        end
      end
    end
  end

  task automatic push(input int idx, input logic [7:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input int idx, input int max);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready[idx] && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready[idx]) check("ready_timeout", 32'(bus.req_ready), 32'd1 << idx);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.active || bus.tx_busy) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (bus.active || bus.tx_busy) check("idle_timeout", {30'd0, bus.active, bus.tx_busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int order [5];
    int prev;
    int extra;
    int n;

    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_lock  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_grant", 32'(bus.grant), 32'd3);
    check("rst_active", 32'(bus.active), 32'd0);
    check("rst_tick", 32'(bus.tx_do_sample), 32'd0);

    // Single byte from requester 0
    @(posedge clk); #1;
    bus.req_data = 32'h0000_0055;
    push(0, 8'h55);
    bus.req_valid = 4'b0001;
    wait_ready(0, 20);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_idle(3000);
    $display("txn single: requester 0 byte 0x55 sent");

    // Contention from a fresh reset: order 0,1,2,3,0
    do_reset();
    order = '{0, 1, 2, 3, 0};
    bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int k = 0; k < 5; k++) push(order[k], 8'hA0 + 8'(order[k]));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ready(order[k], 3000);
      $display("txn contention: grant %0d expected %0d", k, order[k]);
    end
    @(posedge clk); #1 bus.req_valid = '0;
    wait_idle(3000);

    // Baud tick spacing over 2000 cycles after reset
    do_reset();
    prev = -1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (bus.tx_do_sample) begin
        if (prev < 0) check("tick_first", 32'(t), 32'd172);
        else check("tick_period", 32'(t - prev), 32'(CPB));
        prev = t;
      end
    end
    $display("txn tick: last tick at offset %0d", prev);

    // Reset mid-frame with requester 1 held valid
    @(posedge clk); #1;
    bus.req_data = 32'h0000_5A00;
    push(1, 8'h5A);
    bus.req_valid = 4'b0010;
    wait_ready(1, 20);
    repeat (500) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    push(1, 8'h5A);
    extra = 0;
    n = 0;
    @(negedge clk);
    while (bus.tx_busy && n < 3000) begin
      if (bus.req_ready != '0 || bus.tx_start) extra++;
      @(negedge clk);
      n++;
    end
    check("no_accept_while_busy", 32'(extra), 32'd0);
    check("accept_after_busy", 32'(bus.req_ready), 32'b0010);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_idle(3000);
    $display("txn reset_mid_frame: requester 1 re-accepted after busy fell");

    // Glitch on requester 2 while a frame from requester 0 is shifting
    @(posedge clk); #1;
    bus.req_data = 32'h00C3_003C;
    push(0, 8'h3C);
    bus.req_valid = 4'b0001;
    wait_ready(0, 20);
    @(posedge clk); #1 bus.req_valid = '0;
    n = 0;
    while (!bus.tx_busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 4'b0100;
    @(posedge clk); #1 bus.req_valid = '0;
    extra = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.req_ready[2]) extra++;
    end
    check("glitch_no_ready2", 32'(extra), 32'd0);
    check("glitch_tx_data_stable", 32'(bus.tx_data), 32'h3C);
    wait_idle(3000);
    $display("txn glitch: requester 2 pulse ignored");

`ifdef UART_TX_ARBITER_LOCK_EN
    // Packet hold on requester 0, then release to requester 1
    do_reset();
    bus.req_data = 32'h0000_2211;
    push(0, 8'h11); push(0, 8'h11); push(0, 8'h11); push(1, 8'h22);
    bus.req_lock  = 4'b0001;
    bus.req_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      wait_ready(0, 3000);
      $display("txn lock: held grant %0d to requester 0", k);
    end
    @(posedge clk); #1 bus.req_lock = '0;
    wait_ready(1, 3000);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_idle(3000);
    $display("txn lock: released to requester 1");
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
